fpaddsub_result_packer: RTL and testbench
=========================================

FPADDSUB_RESULT_PACKER -- requirements
Module: fpaddsub_result_packer

Interface
REQ-001 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; SHALL clear all state immediately, independent of clk.
REQ-003 in_valid  input  1  input beat present.
REQ-004 in_ready  output  1  block accepts input this cycle.
REQ-005 Sa, Sb  input  1 each  original operand signs.
REQ-006 op  input  1  operation: 0 = add, 1 = subtract.
REQ-007 InputExc  input  5  {anyExc, ANaN, BNaN, AInf, BInf}, same encoding as the pre-align stage.
REQ-008 Sr  input  1  sign of the normalized result.
REQ-009 Er  input  9  biased exponent of the normalized result, unsigned; values 0..511.
REQ-010 Mr  input  24  normalized mantissa; Mr[23] is the hidden bit.
REQ-011 G, R, S  input  1 each  guard, round and sticky bits.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 Result  output  32  IEEE-754 single-precision result.
REQ-015 Flags  output  5  {invalid, overflow, underflow, inexact, zero}.

Function
REQ-016 The datapath SHALL be a 2-stage pipeline: stage 1 rounds, stage 2 applies exception overrides and packs the result.
REQ-017 The pipeline SHALL advance when (~out_valid | out_ready); in_ready SHALL equal this advance term.
REQ-018 A beat SHALL be accepted only when in_valid & in_ready.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-020 Throughput SHALL be 1 beat per cycle when out_ready is held high.
REQ-021 While out_valid & ~out_ready, Result, Flags and out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-022 The stage-1 and stage-2 valid bits SHALL pass bubbles through; an empty stage SHALL not block advance.
REQ-023 Rounding SHALL be round-to-nearest-even: increment Mr when G & (R | S | Mr[0]).
REQ-024 inexact SHALL be set to G | R | S on the normal path.
REQ-025 Mantissa carry-out: if rounding carries out of Mr (0xFFFFFF + 1), the mantissa SHALL become 0x800000 and the exponent SHALL be Er + 1.
REQ-026 Overflow: if the rounded exponent is >= 255, Result SHALL be {Sr, 8'hFF, 23'h0} with overflow = 1 and inexact = 1.
REQ-027 Zero: if Mr == 0 and G = R = S = 0, Result SHALL be {Sr, 31'h0} with zero = 1.
REQ-028 Underflow: if the rounded exponent == 0 or the rounded Mr[23] == 0 with a nonzero value, Result SHALL be {Sr, 31'h0} (flush to zero) with underflow = 1, zero = 1 and inexact = 1.
REQ-029 Normal pack: Result SHALL be {Sr, rounded exponent[7:0], rounded mantissa[22:0]}.
REQ-030 Effective subtraction SHALL be computed as Sa ^ Sb ^ op.
REQ-031 NaN input: if ANaN | BNaN, Result SHALL be 32'h7FC00000 with all flags 0.
REQ-032 Inf minus Inf: if AInf & BInf & effective subtraction, Result SHALL be 32'h7FC00000 with invalid = 1.
REQ-033 Other infinity cases: if AInf, Result SHALL be {Sa, 8'hFF, 23'h0}; otherwise if BInf, Result SHALL be {Sb ^ op, 8'hFF, 23'h0}; in both cases all flags SHALL be 0.
REQ-034 Exception overrides SHALL take priority over the normal path whenever InputExc[4] = 1, in the priority order NaN, then Inf-Inf, then Inf.
REQ-035 Arithmetic SHALL use 10-bit internal exponent width so that Er + 1 cannot wrap.

Reset
REQ-036 When rst is asserted, both stage valid bits, out_valid, Result and Flags SHALL be cleared to 0 asynchronously.
REQ-037 in_ready SHALL evaluate to 1 after reset because out_valid = 0.
REQ-038 Beats in flight when rst asserts mid-operation SHALL be discarded, and no out_valid pulse SHALL follow release of rst.
REQ-039 Operation SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-040 Normal pack: Sr=0, Er=128, Mr=0x800000, G=R=S=0, exc=0 -> Result 0x40000000, Flags 0, out_valid exactly 2 cycles after acceptance.
REQ-041 Carry and tie to even: Er=127, Mr=0xFFFFFF, G=1, R=S=0 -> Result 0x40000000, inexact=1; Er=127, Mr=0x800000, G=1, R=S=0 -> Result 0x3F800000, inexact=1.
REQ-042 Overflow: Er=254, Mr=0xFFFFFF, G=1 -> Result 0x7F800000, overflow=1, inexact=1.
REQ-043 Exceptions: exc=5'b10011, Sa=Sb=0, op=1 -> Result 0x7FC00000, invalid=1; exc=5'b10010, Sa=1 -> Result 0xFF800000, Flags 0; exc=5'b11000 -> Result 0x7FC00000, Flags 0.
REQ-044 Backpressure: stream 4 beats with out_ready low for 3 cycles mid-stream -> in_ready low while stalled, Result stable, all 4 results emitted in order.
REQ-045 Reset mid-operation: assert rst with 2 beats in flight -> out_valid=0 and Result=0 immediately, no stale output after release.

Source files
------------

// File: rtl/fpaddsub_result_packer_if.sv
// fpaddsub_result_packer_if: beat-in / result-out handshake bundle for the FP add/sub result packer
//   master: upstream+downstream side (drives input beat and out_ready)
//   slave : the packer (drives in_ready, out_valid, Result, Flags)
interface fpaddsub_result_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        Sa;
    logic        Sb;
    logic        op;
    logic [4:0]  InputExc;
    logic        Sr;
    logic [8:0]  Er;
    logic [23:0] Mr;
    logic        G;
    logic        R;
    logic        S;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [4:0]  Flags;

    modport master (
        output in_valid, Sa, Sb, op, InputExc, Sr, Er, Mr, G, R, S, out_ready,
        input  in_ready, out_valid, Result, Flags
    );

    modport slave (
        input  in_valid, Sa, Sb, op, InputExc, Sr, Er, Mr, G, R, S, out_ready,
        output in_ready, out_valid, Result, Flags
    );
endinterface

// File: rtl/fpaddsub_result_packer.sv
// fpaddsub_result_packer: 2-stage round (stage 1) and exception-override/pack (stage 2) for FP add/sub
//   clk, rst : clock, async active-high reset
//   io       : slave side of fpaddsub_result_packer_if (valid/ready in, valid/ready out,
//              Result = IEEE-754 single, Flags = {invalid, overflow, underflow, inexact, zero})
module fpaddsub_result_packer (
    input logic                       clk,
    input logic                       rst,
    fpaddsub_result_packer_if.slave   io
);
    logic        adv;
    logic        inc;
    logic [24:0] sum;
    logic [23:0] m_rnd;
    logic [9:0]  e_rnd;
    logic        v1;
    logic        s1_sr;
    logic [9:0]  s1_e;
    logic [23:0] s1_m;
    logic        s1_inx;
    logic        s1_zero;
    logic [4:0]  s1_exc;
    logic        s1_sa;
    logic        s1_sbop;
    logic        s1_eff;
    logic        nan;
    logic        infinf;
    logic        ainf;
    logic        binf;
    logic        ovf;
    logic        unf;
    logic [31:0] res;
    logic [4:0]  flg;

    // Whole pipe moves together; an empty output slot always lets it advance
    assign adv = ~io.out_valid | io.out_ready;
    assign io.in_ready = adv;

    // Round to nearest even; a carry out of the 24-bit mantissa renormalizes to 1.0 and bumps the exponent
    assign inc   = io.G & (io.R | io.S | io.Mr[0]);
    assign sum   = {1'b0, io.Mr} + {24'd0, inc};
    assign m_rnd = sum[24] ? 24'h800000 : sum[23:0];
    assign e_rnd = {1'b0, io.Er} + {9'd0, sum[24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sr   <= 1'b0;
            s1_e    <= 10'd0;
            s1_m    <= 24'd0;
            s1_inx  <= 1'b0;
            s1_zero <= 1'b0;
            s1_exc  <= 5'd0;
            s1_sa   <= 1'b0;
            s1_sbop <= 1'b0;
            s1_eff  <= 1'b0;
        end else if (adv) begin
            v1      <= io.in_valid;
            s1_sr   <= io.Sr;
            s1_e    <= e_rnd;
            s1_m    <= m_rnd;
            s1_inx  <= io.G | io.R | io.S;
            s1_zero <= (io.Mr == 24'd0) & ~(io.G | io.R | io.S);
            s1_exc  <= io.InputExc;
            s1_sa   <= io.Sa;
            s1_sbop <= io.Sb ^ io.op;
            s1_eff  <= io.Sa ^ io.Sb ^ io.op;
        end
    end

    // Overrides only apply when the anyExc summary bit is set
    assign nan    = s1_exc[4] & (s1_exc[3] | s1_exc[2]);
    assign infinf = s1_exc[4] & s1_exc[1] & s1_exc[0] & s1_eff;
    assign ainf   = s1_exc[4] & s1_exc[1];
    assign binf   = s1_exc[4] & s1_exc[0];
    assign ovf    = s1_e >= 10'd255;
    assign unf    = (s1_e == 10'd0) | ~s1_m[23];

    always_comb begin
        res = (nan | infinf) ? 32'h7FC00000 :
              ainf           ? {s1_sa, 8'hFF, 23'h0} :
              binf           ? {s1_sbop, 8'hFF, 23'h0} :
              s1_zero        ? {s1_sr, 31'h0} :
              ovf            ? {s1_sr, 8'hFF, 23'h0} :
              unf            ? {s1_sr, 31'h0} :
                               {s1_sr, s1_e[7:0], s1_m[22:0]};
        flg = nan            ? 5'b00000 :
              infinf         ? 5'b10000 :
              (ainf | binf)  ? 5'b00000 :
              s1_zero        ? 5'b00001 :
              ovf            ? 5'b01010 :
              unf            ? 5'b00111 :
                               {3'b000, s1_inx, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.out_valid <= 1'b0;
            io.Result    <= 32'd0;
            io.Flags     <= 5'd0;
        end else if (adv) begin
            io.out_valid <= v1;
            if (v1) begin
                io.Result <= res;
                io.Flags  <= flg;
            end
        end
    end
endmodule

// File: tb/tb_fpaddsub_result_packer.sv
// tb_fpaddsub_result_packer: randomized + directed scoreboard bench for fpaddsub_result_packer
module tb_fpaddsub_result_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpaddsub_result_packer_if bus();
    fpaddsub_result_packer dut (.clk(clk), .rst(rst), .io(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          stall_left = 0;
    logic [36:0] exp_q[$];
    bit          stall_prev = 0;
    bit          accepted   = 0;
    bit          rand_ready = 0;
    logic [31:0] prev_res;
    logic [4:0]  prev_flg;

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: {Flags, Result} from the rounding and exception rules, using integer arithmetic
    function automatic logic [36:0] model(input logic sa, input logic sb, input logic op,
                                          input logic [4:0] exc, input logic sr, input logic [8:0] er,
                                          input logic [23:0] mr, input logic g, input logic r, input logic s);
        longint m;
        int     e;
        if (exc[4]) begin
            if (exc[3] || exc[2]) return {5'b00000, 32'h7FC00000};
            if (exc[1] && exc[0] && (sa ^ sb ^ op)) return {5'b10000, 32'h7FC00000};
            if (exc[1]) return {5'b00000, sa, 8'hFF, 23'h0};
            if (exc[0]) return {5'b00000, sb ^ op, 8'hFF, 23'h0};
        end
        if (mr == 24'd0 && !g && !r && !s) return {5'b00001, sr, 31'h0};
        m = longint'(mr);
        e = int'(er);
        if (g && (r || s || mr[0])) m = m + 1;
        if (m >= 64'd16777216) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) return {5'b01010, sr, 8'hFF, 23'h0};
        if (e == 0 || m < 64'd8388608) return {5'b00111, sr, 31'h0};
        return {3'b000, g | r | s, 1'b0, sr, 8'(e), 23'(m)};
    endfunction

    // Entered and left at a falling edge; handshakes are judged 3 time units later, before the rising edge
    task automatic step();
        bus.out_ready = (stall_left > 0) ? 1'b0 : rand_ready ? 1'($urandom_range(0, 9) < 7) : 1'b1;
        if (stall_left > 0) stall_left--;
        #3;
        accepted = 0;
        if (stall_prev) begin
            check("hold_valid", 37'(bus.out_valid), 37'd1);
            check("hold_result", 37'(bus.Result), 37'(prev_res));
            check("hold_flags", 37'(bus.Flags), 37'(prev_flg));
        end
        if (bus.out_valid && !bus.out_ready) check("in_ready_stall", 37'(bus.in_ready), 37'd0);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 37'(bus.out_valid), 37'd0);
            else check("result", {bus.Flags, bus.Result}, exp_q.pop_front());
            n_out++;
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.Sa, bus.Sb, bus.op, bus.InputExc, bus.Sr, bus.Er, bus.Mr,
                                  bus.G, bus.R, bus.S));
            accepted = 1;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_res   = bus.Result;
        prev_flg   = bus.Flags;
        @(negedge clk);
    endtask

    task automatic set_fields(input logic sa, input logic sb, input logic op, input logic [4:0] exc,
                              input logic sr, input logic [8:0] er, input logic [23:0] mr,
                              input logic g, input logic r, input logic s);
        bus.Sa = sa; bus.Sb = sb; bus.op = op; bus.InputExc = exc;
        bus.Sr = sr; bus.Er = er; bus.Mr = mr; bus.G = g; bus.R = r; bus.S = s;
    endtask

    task automatic rand_fields();
        int sel_e = $urandom_range(0, 3);
        int sel_m = $urandom_range(0, 5);
        bus.Sa = 1'($urandom); bus.Sb = 1'($urandom); bus.op = 1'($urandom); bus.Sr = 1'($urandom);
        bus.InputExc = ($urandom_range(0, 5) == 0) ? {1'b1, 4'($urandom)} : 5'($urandom_range(0, 15));
        bus.Er = (sel_e == 0) ? 9'($urandom_range(250, 511)) :
                 (sel_e == 1) ? 9'($urandom_range(0, 2)) : 9'($urandom_range(1, 254));
        bus.Mr = (sel_m == 0) ? 24'hFFFFFF :
                 (sel_m == 1) ? 24'($urandom_range(0, 3)) : {1'b1, 23'($urandom)};
        bus.G = 1'($urandom); bus.R = 1'($urandom); bus.S = 1'($urandom);
    endtask

    task automatic send(output int k);
        k = 0;
        bus.in_valid = 1'b1;
        do begin
            step();
            k++;
        end while (!accepted && k < 50);
        check("accept_timeout", 37'(accepted), 37'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() > 0 && k < 40) begin
            step();
            k++;
        end
        check("drain", 37'(exp_q.size()), 37'd0);
    endtask

    // Single beat into an empty pipe with out_ready high: fixed latency and a constant expected result
    task automatic directed(input string tag, input logic [36:0] want);
        int k;
        int lat;
        send(k);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 37'(lat), 37'd2);
        check(tag, {bus.Flags, bus.Result}, want);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(0, 0, 0, 5'd0, 0, 9'd0, 24'd0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("rst_out_valid", 37'(bus.out_valid), 37'd0);
        check("rst_result", 37'(bus.Result), 37'd0);
        check("rst_flags", 37'(bus.Flags), 37'd0);
        check("rst_in_ready", 37'(bus.in_ready), 37'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        set_fields(0, 0, 0, 5'd0, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("normal", {5'b00000, 32'h40000000});
        set_fields(0, 0, 0, 5'd0, 0, 9'd127, 24'hFFFFFF, 1, 0, 0);
        directed("carry", {5'b00010, 32'h40000000});
        set_fields(0, 0, 0, 5'd0, 0, 9'd127, 24'h800000, 1, 0, 0);
        directed("tie_even", {5'b00010, 32'h3F800000});
        set_fields(0, 0, 0, 5'd0, 0, 9'd254, 24'hFFFFFF, 1, 0, 0);
        directed("overflow", {5'b01010, 32'h7F800000});
        set_fields(0, 0, 1, 5'b10011, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("inf_minus_inf", {5'b10000, 32'h7FC00000});
        set_fields(1, 0, 0, 5'b10010, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("a_inf", {5'b00000, 32'hFF800000});
        set_fields(0, 0, 0, 5'b11000, 0, 9'd128, 24'h800000, 1, 1, 1);
        directed("nan", {5'b00000, 32'h7FC00000});
        set_fields(0, 0, 1, 5'b10001, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("b_inf", {5'b00000, 32'hFF800000});
        set_fields(0, 0, 0, 5'b10011, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("inf_plus_inf", {5'b00000, 32'h7F800000});
        set_fields(0, 0, 0, 5'd0, 1, 9'd100, 24'h000000, 0, 0, 0);
        directed("zero", {5'b00001, 32'h80000000});
        set_fields(0, 0, 0, 5'd0, 0, 9'd0, 24'h800000, 0, 0, 0);
        directed("underflow", {5'b00111, 32'h00000000});
        set_fields(0, 0, 0, 5'b01111, 0, 9'd128, 24'hC00000, 0, 1, 0);
        directed("exc_gated", {5'b00010, 32'h40400000});

        // Backpressure: 4 beats with a 3-cycle stall mid-stream
        base = n_out;
        rand_fields(); send(k);
        rand_fields(); send(k);
        stall_left = 3;
        rand_fields(); send(k);
        check("stall_wait", 37'(k), 37'd4);
        rand_fields(); send(k);
        drain();
        check("bp_count", 37'(n_out - base), 37'd4);

        // Random traffic with random backpressure
        rand_ready = 1;
        repeat (400) begin
            if ($urandom_range(0, 9) < 7) begin
                rand_fields();
                send(k);
            end else begin
                step();
            end
        end
        rand_ready = 0;
        drain();

        // Reset with two beats in flight
        rand_fields(); send(k);
        rand_fields(); send(k);
        check("pre_rst_valid", 37'(bus.out_valid), 37'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 37'(bus.out_valid), 37'd0);
        check("midrst_result", 37'(bus.Result), 37'd0);
        check("midrst_flags", 37'(bus.Flags), 37'd0);
        check("midrst_in_ready", 37'(bus.in_ready), 37'd1);
        exp_q.delete();
        stall_prev = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            step();
            check("post_rst_valid", 37'(bus.out_valid), 37'd0);
        end
        set_fields(0, 0, 0, 5'd0, 0, 9'd128, 24'h800000, 0, 0, 0);
        directed("post_rst_beat", {5'b00000, 32'h40000000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
